// File: rtl/control_sequencer_pkg.sv
// control_sequencer_pkg: shared types for the EELE0651 multi-cycle control sequencer
//   state_t  sequencer states
//   OP_*/FN_* opcode and R-type funct encodings
//   ALU_*    alu_op codes
//   ctrl_t   decoded control bundle produced by instr_decoder
package eele0651_pkg;
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_BREAK = 6'h0D;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  typedef logic [3:0] alu_op_t;
  localparam alu_op_t ALU_AND = 4'd0;
  localparam alu_op_t ALU_OR  = 4'd1;
  localparam alu_op_t ALU_ADD = 4'd2;
  localparam alu_op_t ALU_SUB = 4'd6;
  localparam alu_op_t ALU_SLT = 4'd7;
  typedef struct packed {
    logic    rf_write;
    logic    alu_src_imm;
    logic    wb_sel;
    logic    mem_rd;
    logic    mem_wr;
    logic    branch;
    logic    jump;
    alu_op_t alu_op;
  } ctrl_t;
endpackage

// File: rtl/control_sequencer_if.sv
// control_sequencer_if: instruction fetch valid/ready handshake
//   instr        32-bit instruction word
//   instr_valid  instr is valid this cycle
//   instr_ready  sequencer accepts instr
//   master = instruction source, slave = sequencer
interface control_sequencer_if;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  modport master (output instr, output instr_valid, input instr_ready);
  modport slave  (input instr, input instr_valid, output instr_ready);
endinterface

// File: rtl/control_sequencer_decoder.sv
// instr_decoder: combinational IR -> control bundle
//   ir       in   latched instruction word
//   ctrl     out  decoded controls (ctrl_t)
//   illegal  out  unsupported opcode/funct
//   brk      out  break instruction
module instr_decoder
  import eele0651_pkg::*;
(
  input  logic [31:0] ir,
  output ctrl_t       ctrl,
  output logic        illegal,
  output logic        brk
);
  always_comb begin
    ctrl = '0;
    illegal = 1'b0;
    brk = 1'b0;
    case (ir[31:26])
      OP_RTYPE: begin
        ctrl.rf_write = 1'b1;
        case (ir[5:0])
          FN_ADD:   ctrl.alu_op = ALU_ADD;
          FN_SUB:   ctrl.alu_op = ALU_SUB;
          FN_AND:   ctrl.alu_op = ALU_AND;
          FN_OR:    ctrl.alu_op = ALU_OR;
          FN_SLT:   ctrl.alu_op = ALU_SLT;
          FN_BREAK: begin
            ctrl.rf_write = 1'b0;
            brk = 1'b1;
          end
          default: begin
            ctrl.rf_write = 1'b0;
            illegal = 1'b1;
          end
        endcase
      end
      OP_ADDI: begin
        ctrl.rf_write = 1'b1;
        ctrl.alu_src_imm = 1'b1;
        ctrl.alu_op = ALU_ADD;
      end
      OP_LW: begin
        ctrl.rf_write = 1'b1;
        ctrl.alu_src_imm = 1'b1;
        ctrl.wb_sel = 1'b1;
        ctrl.mem_rd = 1'b1;
        ctrl.alu_op = ALU_ADD;
      end
      OP_SW: begin
        ctrl.alu_src_imm = 1'b1;
        ctrl.mem_wr = 1'b1;
        ctrl.alu_op = ALU_ADD;
      end
      OP_BEQ: begin
        ctrl.branch = 1'b1;
        ctrl.alu_op = ALU_SUB;
      end
      OP_J:    ctrl.jump = 1'b1;
      default: illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM for the MIPS-subset datapath
//   clk, clr_n (async active-low)   fetch: instr/instr_valid/instr_ready (slave)
//   f_zero, f_overflow              ALU flags, sampled in EXEC only
//   pc_inc, pc_ld, pc_src, pc_target  program counter control
//   read_reg_1/2, write_reg, rf_write register file control
//   alu_op, alu_src_imm, imm_ext    ALU control
//   wb_sel, dmu_wen                 writeback select / data memory write
//   halted, illegal                 S_HALT and sticky unsupported-instruction flag
//   ovf_trap                        sticky overflow trap (only with OVERFLOW_TRAP_EN defined)
module control_sequencer
  import eele0651_pkg::*;
#(
  parameter int MEM_LAT  = 1,
  parameter int ALU_OP_W = 4
) (
  input  logic                clk,
  input  logic                clr_n,
  control_sequencer_if.slave  fetch,
  input  logic                f_zero,
  input  logic                f_overflow,
  output logic                pc_inc,
  output logic                pc_ld,
  output logic [1:0]          pc_src,
  output logic [25:0]         pc_target,
  output logic [4:0]          read_reg_1,
  output logic [4:0]          read_reg_2,
  output logic [4:0]          write_reg,
  output logic                rf_write,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                alu_src_imm,
  output logic [31:0]         imm_ext,
  output logic                wb_sel,
  output logic                dmu_wen,
  output logic                halted,
`ifdef OVERFLOW_TRAP_EN
  output logic                ovf_trap,
`endif
  output logic                illegal
);
  localparam int CW = MEM_LAT > 1 ? $clog2(MEM_LAT) : 1;
  localparam logic [CW-1:0] LAST = CW'(MEM_LAT - 1);
  state_t        state;
  logic [31:0]   ir;
  logic [CW-1:0] cnt;
  ctrl_t         ctrl;
  logic          dec_illegal;
  logic          brk;
  logic          trap;
  logic          last;
  instr_decoder u_dec (.ir(ir), .ctrl(ctrl), .illegal(dec_illegal), .brk(brk));
`ifdef OVERFLOW_TRAP_EN
  // lw also adds, but only add/sub/addi retire an arithmetic result that can overflow
  assign trap = f_overflow && ctrl.rf_write && !ctrl.mem_rd &&
                (ctrl.alu_op == ALU_ADD || ctrl.alu_op == ALU_SUB);
`else
  logic unused_ovf;
  assign unused_ovf = f_overflow;
  assign trap = 1'b0;
`endif
  assign last = cnt == LAST;
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state <= S_FETCH;
      ir <= '0;
      cnt <= '0;
      illegal <= 1'b0;
`ifdef OVERFLOW_TRAP_EN
      ovf_trap <= 1'b0;
`endif
    end else begin
      case (state)
        S_FETCH: if (fetch.instr_valid) begin
          ir <= fetch.instr;
          state <= S_DECODE;
        end
        S_DECODE: begin
          illegal <= dec_illegal;
          state <= dec_illegal || brk ? S_HALT : ctrl.jump ? S_FETCH : S_EXEC;
        end
        S_EXEC: begin
          cnt <= '0;
`ifdef OVERFLOW_TRAP_EN
          ovf_trap <= trap;
`endif
          state <= ctrl.branch ? S_FETCH : trap ? S_HALT :
                   ctrl.mem_rd || ctrl.mem_wr ? S_MEM : S_WB;
        end
        S_MEM: begin
          cnt <= last ? '0 : cnt + 1'b1;
          if (last) state <= ctrl.mem_rd ? S_WB : S_FETCH;
        end
        S_WB:    state <= S_FETCH;
        default: state <= S_HALT;
      endcase
    end
  end
  assign fetch.instr_ready = state == S_FETCH;
  assign halted      = state == S_HALT;
  assign read_reg_1  = ir[25:21];
  assign read_reg_2  = ir[20:16];
  assign write_reg   = ir[31:26] == OP_RTYPE ? ir[15:11] : ir[20:16];
  assign imm_ext     = {{16{ir[15]}}, ir[15:0]};
  assign pc_target   = ctrl.jump ? ir[25:0] : {{10{ir[15]}}, ir[15:0]};
  assign alu_op      = ALU_OP_W'(ctrl.alu_op);
  assign alu_src_imm = ctrl.alu_src_imm;
  assign wb_sel      = ctrl.wb_sel;
  assign rf_write    = state == S_WB;
  // store write pulses only on the first MEM cycle; the store retires on the last
  assign dmu_wen     = state == S_MEM && ctrl.mem_wr && cnt == '0;
  assign pc_inc      = state == S_WB || (state == S_MEM && ctrl.mem_wr && last) ||
                       (state == S_EXEC && ctrl.branch && !f_zero);
  assign pc_ld       = (state == S_EXEC && ctrl.branch && f_zero) ||
                       (state == S_DECODE && ctrl.jump);
  assign pc_src      = {pc_ld & ctrl.jump, pc_ld & ctrl.branch};
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed scoreboard bench for control_sequencer (MEM_LAT=2)
module tb_control_sequencer;
  import eele0651_pkg::*;
  localparam logic [7:0] R = 8'h80, RFW = 8'h40, INC = 8'h20, LD = 8'h10;
  localparam logic [7:0] SJ = 8'h08, SB = 8'h04, WEN = 8'h02, HLT = 8'h01;
  logic clk = 1'b0, clr_n = 1'b0, f_zero = 1'b0, f_overflow = 1'b0;
  logic pc_inc, pc_ld, rf_write, alu_src_imm, wb_sel, dmu_wen, halted, illegal;
  logic [1:0] pc_src;
  logic [25:0] pc_target;
  logic [4:0] read_reg_1, read_reg_2, write_reg;
  logic [3:0] alu_op;
  logic [31:0] imm_ext;
  logic [7:0] obs_v;
`ifdef OVERFLOW_TRAP_EN
  logic ovf_trap;
`endif
  control_sequencer_if fi ();
  control_sequencer #(.MEM_LAT(2), .ALU_OP_W(4)) dut (
    .clk(clk), .clr_n(clr_n), .fetch(fi.slave), .f_zero(f_zero), .f_overflow(f_overflow),
    .pc_inc(pc_inc), .pc_ld(pc_ld), .pc_src(pc_src), .pc_target(pc_target),
    .read_reg_1(read_reg_1), .read_reg_2(read_reg_2), .write_reg(write_reg),
    .rf_write(rf_write), .alu_op(alu_op), .alu_src_imm(alu_src_imm), .imm_ext(imm_ext),
    .wb_sel(wb_sel), .dmu_wen(dmu_wen), .halted(halted),
`ifdef OVERFLOW_TRAP_EN
    .ovf_trap(ovf_trap),
`endif
    .illegal(illegal)
  );
  always #5 clk = ~clk;
  assign obs_v = {fi.instr_ready, rf_write, pc_inc, pc_ld, pc_src, dmu_wen, halted};
  typedef struct {
    string      tag;
    logic [7:0] v;
    logic       lvl;
    logic [4:0] wreg;
    logic [3:0] alu;
    logic       wb;
  } exp_t;
  exp_t sb[$];
  int checks = 0, failures = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic push(input string tag, input logic [7:0] v);
    sb.push_back('{tag, v, 1'b0, 5'd0, 4'd0, 1'b0});
  endtask
  task automatic push_lvl(input string tag, input logic [7:0] v, input logic [4:0] wreg,
                          input logic [3:0] alu, input logic wb);
    sb.push_back('{tag, v, 1'b1, wreg, alu, wb});
  endtask
  task automatic issue(input logic [31:0] w);
    exp_t e;
    fi.instr = w;
    fi.instr_valid = 1'b1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk({e.tag, "/strobes"}, 32'(obs_v), 32'(e.v));
      if (e.lvl) begin
        chk({e.tag, "/write_reg"}, 32'(write_reg), 32'(e.wreg));
        chk({e.tag, "/alu_op"}, 32'(alu_op), 32'(e.alu));
        chk({e.tag, "/wb_sel"}, 32'(wb_sel), 32'(e.wb));
      end
      @(posedge clk);
      @(negedge clk);
      fi.instr_valid = 1'b0;
    end
  endtask
  task automatic do_reset();
    fi.instr_valid = 1'b0;
    clr_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    clr_n = 1'b1;
  endtask
  initial begin
    fi.instr = '0;
    fi.instr_valid = 1'b0;
    @(negedge clk);
    chk("rst/strobes", 32'(obs_v), 32'(R));
    chk("rst/illegal", 32'(illegal), 32'd0);
    @(posedge clk);
    @(negedge clk);
    clr_n = 1'b1;
    push("add/c1", R); push("add/c2", 0); push("add/c3", 0);
    push_lvl("add/wb", RFW | INC, 5'd3, 4'd2, 1'b0);
    issue(32'h00221820);
    push("lw/c1", R); push("lw/c2", 0); push("lw/c3", 0); push("lw/m1", 0); push("lw/m2", 0);
    push_lvl("lw/wb", RFW | INC, 5'd4, 4'd2, 1'b1);
    issue(32'h8C040008);
    push("sw/c1", R); push("sw/c2", 0); push("sw/c3", 0);
    push_lvl("sw/m1", WEN, 5'd4, 4'd2, 1'b0); push("sw/m2", INC);
    issue(32'hAC04000C);
    f_zero = 1'b1;
    push("beqT/c1", R); push("beqT/c2", 0);
    push_lvl("beqT/ex", LD | SB, 5'd1, 4'd6, 1'b0);
    issue(32'h10210004);
    chk("beqT/pc_target", 32'(pc_target), 32'h4);
    f_zero = 1'b0;
    push("beqN/c1", R); push("beqN/c2", 0); push("beqN/ex", INC);
    issue(32'h10210004);
    push("j/c1", R); push("j/c2", LD | SJ);
    issue(32'h08000010);
    chk("j/pc_target", 32'(pc_target), 32'h10);
    f_overflow = 1'b1;
    push("addi/c1", R); push("addi/c2", 0); push("addi/c3", 0);
`ifdef OVERFLOW_TRAP_EN
    push("addi/trap", HLT);
    issue(32'h20C50001);
    chk("addi/ovf_trap", 32'(ovf_trap), 32'd1);
    f_overflow = 1'b0;
    do_reset();
    chk("addi/ovf_clr", 32'(ovf_trap), 32'd0);
`else
    push_lvl("addi/wb", RFW | INC, 5'd5, 4'd2, 1'b0);
    issue(32'h20C50001);
    f_overflow = 1'b0;
`endif
    push("swrst/c1", R); push("swrst/c2", 0); push("swrst/c3", 0);
    issue(32'hAC04000C);
    chk("swrst/wen_before", 32'(dmu_wen), 32'd1);
    clr_n = 1'b0;
    #1;
    chk("swrst/wen_abort", 32'(dmu_wen), 32'd0);
    chk("swrst/ready_in_rst", 32'(fi.instr_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    clr_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("swrst/after", 32'(obs_v), 32'(R));
    push("brk/c1", R); push("brk/c2", 0); push("brk/halt", HLT);
    issue(32'h0000000D);
    fi.instr_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("brk/absorb", 32'(obs_v), 32'(HLT));
      @(posedge clk);
      @(negedge clk);
    end
    chk("brk/illegal", 32'(illegal), 32'd0);
    do_reset();
    push("ill/c1", R); push("ill/c2", 0); push("ill/halt", HLT);
    issue(32'hFC000000);
    chk("ill/illegal", 32'(illegal), 32'd1);
    do_reset();
    chk("ill/cleared", 32'(illegal), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
